// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU definitions: fetch bus FSM states, reset vector, queue entry.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

    localparam int CPU_ADDR_WIDTH = 16;
    localparam int CPU_DATA_WIDTH = 8;

    localparam logic [CPU_ADDR_WIDTH-1:0] CPU_RESET_PC = 16'h2000;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_READ = 1'b1
    } Fetch_state;

    typedef struct packed {
        logic [CPU_DATA_WIDTH-1:0] data;
        logic [CPU_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    // Occupancy counters need one extra bit so that a full queue is representable.
    function automatic int fetch_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_if
// Brief  : Memory bus and decoder-side signals of the instruction fetch unit.
// Rev    : 1.0
// ============================================================================
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CW = fetch_count_width(DEPTH);

    logic [ADDR_WIDTH-1:0] adress_bus;
    logic [DATA_WIDTH-1:0] date_bus;
    logic                  r;
    logic                  ready;

    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;

    logic                  instr_take;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_byte;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [CW-1:0]         count;

    modport master (
        output adress_bus, r, instr_valid, instr_byte, instr_pc, count,
        input  date_bus, ready, stall, flush, flush_pc, instr_take
    );

    modport slave (
        input  adress_bus, r, instr_valid, instr_byte, instr_pc, count,
        output date_bus, ready, stall, flush, flush_pc, instr_take
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : Circular prefetch buffer with push, pop and a priority clear.
// Rev    : 1.0
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = fetch_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch front end: wait-state bus reads into a prefetch queue.
// Rev    : 1.0
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = fetch_count_width(DEPTH);
    localparam int EW = DATA_WIDTH + ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    Fetch_state            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    logic                  q_push;
    logic                  q_pop;
    logic                  q_clear;
    logic                  q_valid;
    logic [CW-1:0]         q_count;
    logic [CW-1:0]         count_after_take;
    entry_t                push_entry;
    entry_t                head_entry;
    logic [EW-1:0]         head_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BUS_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        q_push           = 1'b0;
        q_clear          = 1'b0;
        q_pop            = bus.instr_take && q_valid && !bus.flush;
        push_entry       = '{data: bus.date_bus, pc: pc_q};
        count_after_take = q_count - CW'(q_pop);

        if (bus.flush) begin
            // Abandons any in-flight read: its data is dropped and pc is not advanced.
            q_clear = 1'b1;
            pc_d    = bus.flush_pc;
            state_d = BUS_IDLE;
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    if (!bus.stall && (count_after_take < CW'(DEPTH))) begin
                        state_d = BUS_READ;
                    end
                end
                BUS_READ: begin
                    if (bus.ready) begin
                        q_push  = 1'b1;
                        pc_d    = pc_q + ADDR_WIDTH'(1);
                        state_d = BUS_IDLE;
                    end
                end
                default: state_d = BUS_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (q_clear),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .head_o      (head_bits),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    assign head_entry      = entry_t'(head_bits);

    // pc only moves on a capture or flush edge, so the address is stable for a whole read.
    assign bus.adress_bus  = pc_q;
    assign bus.r           = (state_q == BUS_READ);
    assign bus.count       = q_count;
    assign bus.instr_valid = q_valid;
    assign bus.instr_byte  = head_entry.data;
    assign bus.instr_pc    = head_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } ent_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_key = '0;
    int            errors = 0;
    int            checks = 0;

    ent_t          m_q[$];
    bit            m_reading;
    logic [AW-1:0] m_pc;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    assign bus.date_bus = bus.adress_bus[7:0] ^ data_key;

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (16'h2000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_reading = 1'b0;
        m_pc      = 16'h2000;
    endtask

    // Reference behaviour of one clock edge, from the fetch rules.
    task automatic model_edge();
        ent_t e;
        if (bus.flush) begin
            m_q.delete();
            m_pc      = bus.flush_pc;
            m_reading = 1'b0;
        end else begin
            if (bus.instr_take && m_q.size() > 0) void'(m_q.pop_front());
            if (m_reading) begin
                if (bus.ready) begin
                    e.data = m_pc[7:0] ^ data_key;
                    e.pc   = m_pc;
                    m_q.push_back(e);
                    m_pc      = m_pc + 16'd1;
                    m_reading = 1'b0;
                end
            end else if (!bus.stall && m_q.size() < DEPTH) begin
                m_reading = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.ready      = 1'b1;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        bus.instr_take = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.r !== 1'b0) begin errors++; $display("FAIL reset_r got=%b exp=0", bus.r); end
        checks++; if (bus.adress_bus !== 16'h2000) begin errors++; $display("FAIL reset_addr got=%h exp=2000", bus.adress_bus); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
        reset = 1'b0;
        model_reset();
        step();
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2000) begin
            errors++; $display("FAIL first_read got r=%b addr=%h exp r=1 addr=2000", bus.r, bus.adress_bus);
        end
    endtask

    task automatic test_fill();
        logic          exp_r;
        logic [AW-1:0] exp_a;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_r = (k % 2 == 1) && (k <= 7);
            exp_a = 16'h2000 + AW'((k - 1) / 2);
            checks++;
            if (bus.r !== exp_r || (exp_r && bus.adress_bus !== exp_a)) begin
                errors++; $display("FAIL fill_bus cyc=%0d got r=%b addr=%h exp r=%b addr=%h", k, bus.r, bus.adress_bus, exp_r, exp_a);
            end
        end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_byte !== 8'h00 || bus.instr_pc !== 16'h2000) begin
            errors++; $display("FAIL fill_head got v=%b b=%h pc=%h exp v=1 b=00 pc=2000", bus.instr_valid, bus.instr_byte, bus.instr_pc);
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        step();
        step();
        step();
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2001) begin
            errors++; $display("FAIL wait_issue got r=%b addr=%h exp r=1 addr=2001", bus.r, bus.adress_bus);
        end
        bus.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2001 || bus.count !== 3'd1) begin
                errors++; $display("FAIL wait_hold cyc=%0d got r=%b addr=%h cnt=%0d exp r=1 addr=2001 cnt=1", k, bus.r, bus.adress_bus, bus.count);
            end
        end
        bus.ready = 1'b1;
        step();
        checks++; if (bus.r !== 1'b0 || bus.count !== 3'd2) begin
            errors++; $display("FAIL wait_done got r=%b cnt=%0d exp r=0 cnt=2", bus.r, bus.count);
        end
    endtask

    task automatic test_flush();
        step();
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2002) begin
            errors++; $display("FAIL flush_pre got r=%b addr=%h exp r=1 addr=2002", bus.r, bus.adress_bus);
        end
        bus.flush    = 1'b1;
        bus.flush_pc = 16'h4000;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.r !== 1'b0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got cnt=%0d r=%b v=%b exp cnt=0 r=0 v=0", bus.count, bus.r, bus.instr_valid);
        end
        step();
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h4000 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL flush_issue got r=%b addr=%h v=%b exp r=1 addr=4000 v=0", bus.r, bus.adress_bus, bus.instr_valid);
        end
        step();
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h4000 || bus.instr_byte !== 8'h00 || bus.count !== 3'd1) begin
            errors++; $display("FAIL flush_first got v=%b pc=%h b=%h cnt=%0d exp v=1 pc=4000 b=00 cnt=1", bus.instr_valid, bus.instr_pc, bus.instr_byte, bus.count);
        end
    endtask

    task automatic test_pc_wrap();
        logic [AW-1:0] exp_pc [3];
        exp_pc[0] = 16'hFFFF;
        exp_pc[1] = 16'h0000;
        exp_pc[2] = 16'h0001;
        apply_reset();
        bus.flush    = 1'b1;
        bus.flush_pc = 16'hFFFF;
        step();
        bus.flush = 1'b0;
        repeat (6) step();
        bus.stall = 1'b1;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", bus.count); end
        bus.instr_take = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[i] || bus.instr_byte !== exp_pc[i][7:0]) begin
                errors++; $display("FAIL wrap_pc idx=%0d got v=%b pc=%h b=%h exp pc=%h", i, bus.instr_valid, bus.instr_pc, bus.instr_byte, exp_pc[i]);
            end
            step();
        end
        bus.instr_take = 1'b0;
        bus.stall      = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_pc;
        bit            popping;
        apply_reset();
        repeat (9) step();
        checks++; if (bus.count !== 3'd4 || bus.r !== 1'b0) begin
            errors++; $display("FAIL b2b_full got cnt=%0d r=%b exp cnt=4 r=0", bus.count, bus.r);
        end
        bus.instr_take = 1'b1;
        exp_pc = 16'h2000;
        step();
        exp_pc = exp_pc + 16'd1;
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2004) begin
            errors++; $display("FAIL b2b_take_issue got r=%b addr=%h exp r=1 addr=2004", bus.r, bus.adress_bus);
        end
        for (int k = 0; k < 30; k++) begin
            popping = (m_q.size() != 0);
            step();
            if (popping) exp_pc = exp_pc + 16'd1;
            checks++; if (bus.count > 3'd4 || bus.count !== 3'(m_q.size())) begin
                errors++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", k, bus.count, m_q.size());
            end
            checks++; if (bus.r !== m_reading) begin
                errors++; $display("FAIL b2b_r cyc=%0d got=%b exp=%b", k, bus.r, m_reading);
            end
            if (m_q.size() != 0) begin
                checks++; if (bus.instr_pc !== exp_pc) begin
                    errors++; $display("FAIL b2b_pc cyc=%0d got=%h exp=%h", k, bus.instr_pc, exp_pc);
                end
            end
        end
        bus.instr_take = 1'b0;
    endtask

    task automatic test_reset_midread();
        apply_reset();
        step();
        step();
        bus.ready = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.r !== 1'b0 || bus.instr_valid !== 1'b0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL midread_async got r=%b v=%b cnt=%0d exp r=0 v=0 cnt=0", bus.r, bus.instr_valid, bus.count);
        end
        bus.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.r !== 1'b0 || bus.count !== 3'd0 || bus.adress_bus !== 16'h2000) begin
            errors++; $display("FAIL midread_hold got r=%b cnt=%0d addr=%h exp r=0 cnt=0 addr=2000", bus.r, bus.count, bus.adress_bus);
        end
        reset = 1'b0;
        model_reset();
        step();
        checks++; if (bus.r !== 1'b1 || bus.adress_bus !== 16'h2000 || bus.count !== 3'd0) begin
            errors++; $display("FAIL midread_restart got r=%b addr=%h cnt=%0d exp r=1 addr=2000 cnt=0", bus.r, bus.adress_bus, bus.count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        data_key = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            bus.ready      = ($urandom_range(0, 3) != 0);
            bus.stall      = ($urandom_range(0, 7) == 0);
            bus.instr_take = ($urandom_range(0, 2) == 0);
            bus.flush      = ($urandom_range(0, 40) == 0);
            bus.flush_pc   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            step();
            checks++; if (bus.r !== m_reading) begin
                errors++; $display("FAIL rand_r cyc=%0d got=%b exp=%b", c, bus.r, m_reading);
            end
            if (m_reading) begin
                checks++; if (bus.adress_bus !== m_pc) begin
                    errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, bus.adress_bus, m_pc);
                end
            end
            checks++; if (bus.count !== 3'(m_q.size()) || bus.instr_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_count cyc=%0d got cnt=%0d v=%b exp cnt=%0d", c, bus.count, bus.instr_valid, m_q.size());
            end
            if (m_q.size() != 0) begin
                checks++; if (bus.instr_byte !== m_q[0].data || bus.instr_pc !== m_q[0].pc) begin
                    errors++; $display("FAIL rand_head cyc=%0d got b=%h pc=%h exp b=%h pc=%h", c, bus.instr_byte, bus.instr_pc, m_q[0].data, m_q[0].pc);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill();
        test_wait_states();
        test_flush();
        test_pc_wrap();
        test_back_to_back();
        test_reset_midread();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
